// File: rtl/musb_multiport_memory.sv
// N-port word memory: byte-lane writes, fixed wait states, enable/ready handshake,
// out-of-range error strobe. Each port runs its own IDLE/WAIT controller and shares
// only the storage array.
module musb_multiport_memory #(
  parameter int    N_PORTS       = 2,
  parameter int    ADDR_WIDTH    = 12,
  parameter int    DATA_WIDTH    = 32,
  parameter int    MEM_WORDS     = 4096,
  parameter int    WAIT_STATES   = 1,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]    port_addr,
  input  logic [N_PORTS*DATA_WIDTH-1:0]    port_din,
  input  logic [N_PORTS*(DATA_WIDTH/8)-1:0] port_wr,
  input  logic [N_PORTS-1:0]               port_enable,
  output logic [N_PORTS*DATA_WIDTH-1:0]    port_dout,
  output logic [N_PORTS-1:0]               port_ready,
  output logic [N_PORTS-1:0]               port_error
);

  localparam int BE    = DATA_WIDTH / 8;
  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] WS_RELOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e                r_state     [N_PORTS];
  state_e                w_state_nxt [N_PORTS];
  logic [3:0]            r_cnt       [N_PORTS];
  logic [3:0]            w_cnt_nxt   [N_PORTS];
  logic [DATA_WIDTH-1:0] r_dout      [N_PORTS];
  logic [N_PORTS-1:0]    r_ready;
  logic [N_PORTS-1:0]    r_error;

  logic [ADDR_WIDTH-1:0] w_addr [N_PORTS];
  logic [IDX_W-1:0]      w_idx  [N_PORTS];
  logic [DATA_WIDTH-1:0] w_din  [N_PORTS];
  logic [BE-1:0]         w_wr   [N_PORTS];
  logic [N_PORTS-1:0]    w_inrange;
  logic [N_PORTS-1:0]    w_access;

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  // Unpack the flattened per-port buses and classify each address.
  always_comb begin
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      w_addr[p]    = port_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      w_din[p]     = port_din[p*DATA_WIDTH +: DATA_WIDTH];
      w_wr[p]      = port_wr[p*BE +: BE];
      w_idx[p]     = w_addr[p][IDX_W-1:0];
      w_inrange[p] = ({1'b0, w_addr[p]} < MEM_LIMIT);
    end
  end

  // Per-port next state, wait counter and access-edge decision.
  always_comb begin
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      w_state_nxt[p] = r_state[p];
      w_cnt_nxt[p]   = r_cnt[p];
      w_access[p]    = 1'b0;
      case (r_state[p])
        ST_IDLE: begin
          if (port_enable[p]) begin
            if (WAIT_STATES == 0) begin
              w_access[p] = 1'b1;
            end else begin
              w_cnt_nxt[p]   = WS_RELOAD;
              w_state_nxt[p] = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!port_enable[p]) begin
            w_state_nxt[p] = ST_IDLE;
            w_cnt_nxt[p]   = '0;
          end else if (r_cnt[p] != 4'd0) begin
            w_cnt_nxt[p] = r_cnt[p] - 4'd1;
          end else begin
            w_access[p]    = 1'b1;
            w_state_nxt[p] = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt[p] = ST_IDLE;
          w_cnt_nxt[p]   = '0;
        end
      endcase
    end
  end

  // Byte-lane writes. Ports are visited from highest to lowest index so the last
  // non-blocking update, i.e. the lowest-index port, owns each contested lane.
  always_ff @(posedge clk) begin
    for (int unsigned q = 0; q < N_PORTS; q++) begin
      for (int unsigned b = 0; b < BE; b++) begin
        if (w_access[N_PORTS-1-q] && w_inrange[N_PORTS-1-q] && w_wr[N_PORTS-1-q][b]) begin
          r_mem[w_idx[N_PORTS-1-q]][b*8 +: 8] <= w_din[N_PORTS-1-q][b*8 +: 8];
        end
      end
    end
  end

  // Controller state, read data capture (pre-write value) and completion strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        r_state[p] <= ST_IDLE;
        r_cnt[p]   <= '0;
        r_dout[p]  <= '0;
      end
      r_ready <= '0;
      r_error <= '0;
    end else begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        r_state[p] <= w_state_nxt[p];
        r_cnt[p]   <= w_cnt_nxt[p];
        r_ready[p] <= w_access[p] && w_inrange[p];
        r_error[p] <= w_access[p] && !w_inrange[p];
        if (w_access[p]) begin
          r_dout[p] <= w_inrange[p] ? r_mem[w_idx[p]] : '0;
        end
      end
    end
  end

  // Repack read data onto the flattened output bus.
  always_comb begin
    port_dout = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      port_dout[p*DATA_WIDTH +: DATA_WIDTH] = r_dout[p];
    end
  end

  assign port_ready = r_ready;
  assign port_error = r_error;

endmodule

// File: tb/tb_musb_multiport_memory.sv
// Self-checking bench: three instances (3 ports/1 wait, 1 port/3 waits, 1 port/0 waits)
// checked against an array-based model of the memory.
module tb_musb_multiport_memory;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vec = 0;
  int errs = 0;

  // Instance A: 3 ports, 1 wait state, 1024 words
  logic [35:0] a_addr = '0;
  logic [95:0] a_din  = '0;
  logic [11:0] a_wr   = '0;
  logic [2:0]  a_en   = '0;
  logic [95:0] a_dout;
  logic [2:0]  a_rdy, a_err;

  // Instance B: 1 port, 3 wait states
  logic [11:0] b_addr = '0;
  logic [31:0] b_din  = '0;
  logic [3:0]  b_wr   = '0;
  logic        b_en   = 1'b0;
  logic [31:0] b_dout;
  logic        b_rdy, b_err;

  // Instance C: 1 port, 0 wait states
  logic [11:0] c_addr = '0;
  logic [31:0] c_din  = '0;
  logic [3:0]  c_wr   = '0;
  logic        c_en   = 1'b0;
  logic [31:0] c_dout;
  logic        c_rdy, c_err;

  musb_multiport_memory #(.N_PORTS(3), .ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_WORDS(1024), .WAIT_STATES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .port_addr(a_addr), .port_din(a_din), .port_wr(a_wr),
    .port_enable(a_en), .port_dout(a_dout), .port_ready(a_rdy), .port_error(a_err));

  musb_multiport_memory #(.N_PORTS(1), .ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_WORDS(1024), .WAIT_STATES(3)) u_b (
    .clk(clk), .rst_n(rst_n), .port_addr(b_addr), .port_din(b_din), .port_wr(b_wr),
    .port_enable(b_en), .port_dout(b_dout), .port_ready(b_rdy), .port_error(b_err));

  musb_multiport_memory #(.N_PORTS(1), .ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_WORDS(1024), .WAIT_STATES(0)) u_c (
    .clk(clk), .rst_n(rst_n), .port_addr(c_addr), .port_din(c_din), .port_wr(c_wr),
    .port_enable(c_en), .port_dout(c_dout), .port_ready(c_rdy), .port_error(c_err));

  // Reference contents of instance A
  logic [31:0] ma [1024];
  logic [31:0] mc [1024];

  // Model of one simultaneous transaction on A: reads see the old word, then writes
  // are applied lane by lane with the lowest-index writer to a word taking the lane.
  function automatic void a_model(input logic [2:0] en, input logic [35:0] addr,
                                  input logic [95:0] din, input logic [11:0] wr,
                                  output logic [2:0] rdy, output logic [2:0] err,
                                  output logic [95:0] dout);
    int ad [3];
    bit taken;
    rdy = '0; err = '0; dout = '0;
    for (int p = 0; p < 3; p++) begin
      ad[p] = int'(addr[p*12 +: 12]);
      if (en[p]) begin
        if (ad[p] >= 1024) err[p] = 1'b1;
        else begin
          rdy[p] = 1'b1;
          dout[p*32 +: 32] = ma[ad[p]];
        end
      end
    end
    for (int b = 0; b < 4; b++) begin
      for (int p = 0; p < 3; p++) begin
        if (rdy[p] && wr[p*4+b]) begin
          taken = 1'b0;
          for (int q = 0; q < p; q++)
            if (rdy[q] && wr[q*4+b] && ad[q] == ad[p]) taken = 1'b1;
          if (!taken) ma[ad[p]][b*8 +: 8] = din[p*32 + b*8 +: 8];
        end
      end
    end
  endfunction

  // Drive one transaction on A; capture the strobe cycle and whether strobes clear after.
  task automatic a_txn(input logic [2:0] en, input logic [35:0] addr, input logic [95:0] din,
                       input logic [11:0] wr, output logic [2:0] rdy, output logic [2:0] err,
                       output logic [95:0] dout, output int lat, output bit clr);
    @(negedge clk);
    a_en = en; a_addr = addr; a_din = din; a_wr = wr;
    lat = -1; rdy = '0; err = '0; dout = '0; clr = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((a_rdy | a_err) != 3'b000) begin
        lat = i; rdy = a_rdy; err = a_err; dout = a_dout;
        break;
      end
    end
    a_en = '0;
    @(negedge clk);
    clr = (a_rdy == 3'b000) && (a_err == 3'b000);
  endtask

  task automatic a_one(input int p, input logic [11:0] addr, input logic [31:0] din,
                       input logic [3:0] wr, output logic [2:0] rdy, output logic [2:0] err,
                       output logic [95:0] dout, output int lat, output bit clr);
    logic [35:0] av; logic [95:0] dv; logic [11:0] wv; logic [2:0] ev;
    av = '0; dv = '0; wv = '0; ev = '0;
    av[p*12 +: 12] = addr; dv[p*32 +: 32] = din; wv[p*4 +: 4] = wr; ev[p] = 1'b1;
    a_txn(ev, av, dv, wv, rdy, err, dout, lat, clr);
    a_model(ev, av, dv, wv, rdy, err, dv);
  endtask

  task automatic b_txn(input logic [11:0] addr, input logic [31:0] din, input logic [3:0] wr,
                       output logic [31:0] dout, output logic rdy, output logic err, output int lat);
    @(negedge clk);
    b_en = 1'b1; b_addr = addr; b_din = din; b_wr = wr;
    lat = -1; rdy = 1'b0; err = 1'b0; dout = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (b_rdy || b_err) begin
        lat = i; rdy = b_rdy; err = b_err; dout = b_dout;
        break;
      end
    end
    b_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    vec++;
    if ({a_dout, a_rdy, a_err} !== '0) begin
      errs++; $display("FAIL reset_a: got %h expected 0", {a_dout, a_rdy, a_err});
    end
    vec++;
    if ({b_dout, b_rdy, b_err, c_dout, c_rdy, c_err} !== '0) begin
      errs++; $display("FAIL reset_bc: got %h expected 0", {b_dout, b_rdy, b_err, c_dout, c_rdy, c_err});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read_latency();
    logic [2:0] r, e; logic [95:0] d; int lat; bit clr;
    a_one(0, 12'h010, 32'hDEADBEEF, 4'hF, r, e, d, lat, clr);
    a_one(0, 12'h010, 32'h0, 4'h0, r, e, d, lat, clr);
    vec++;
    if (lat !== 2) begin errs++; $display("FAIL read_latency: got %0d expected 2", lat); end
    vec++;
    if (d[31:0] !== 32'hDEADBEEF) begin errs++; $display("FAIL read_data: got %h expected deadbeef", d[31:0]); end
    vec++;
    if (r !== 3'b001 || e !== 3'b000 || !clr) begin
      errs++; $display("FAIL read_strobe: got rdy=%b err=%b clr=%0d expected 001 000 1", r, e, clr);
    end
  endtask

  task automatic test_byte_lanes();
    logic [2:0] r, e; logic [95:0] d; int lat; bit clr;
    a_one(1, 12'h020, 32'hAAAAAAAA, 4'hF, r, e, d, lat, clr);
    a_one(1, 12'h020, 32'h11223344, 4'b0101, r, e, d, lat, clr);
    vec++;
    if (r !== 3'b010 || lat !== 2) begin errs++; $display("FAIL lane_write: got rdy=%b lat=%0d expected 010 2", r, lat); end
    a_one(1, 12'h020, 32'h0, 4'h0, r, e, d, lat, clr);
    vec++;
    if (d[63:32] !== 32'hAA22AA44) begin errs++; $display("FAIL lane_read: got %h expected aa22aa44", d[63:32]); end
  endtask

  task automatic test_same_edge();
    logic [2:0] r, e, er, ee; logic [95:0] d, ed; int lat; bit clr;
    a_one(0, 12'h030, 32'h55555555, 4'hF, r, e, d, lat, clr);
    a_txn(3'b111, {12'h030, 12'h030, 12'h030}, {32'h0, 32'h2, 32'h1}, {4'h0, 4'hF, 4'hF}, r, e, d, lat, clr);
    a_model(3'b111, {12'h030, 12'h030, 12'h030}, {32'h0, 32'h2, 32'h1}, {4'h0, 4'hF, 4'hF}, er, ee, ed);
    vec++;
    if (d[95:64] !== 32'h55555555) begin errs++; $display("FAIL same_edge_read: got %h expected 55555555", d[95:64]); end
    vec++;
    if (r !== 3'b111 || e !== 3'b000) begin errs++; $display("FAIL same_edge_strobe: got rdy=%b err=%b expected 111 000", r, e); end
    a_one(2, 12'h030, 32'h0, 4'h0, r, e, d, lat, clr);
    vec++;
    if (d[95:64] !== 32'h00000001) begin errs++; $display("FAIL same_edge_winner: got %h expected 00000001", d[95:64]); end
  endtask

  task automatic test_out_of_range();
    logic [2:0] r, e; logic [95:0] d; int lat; bit clr;
    a_one(0, 12'h000, 32'h0BADF00D, 4'hF, r, e, d, lat, clr);
    a_one(0, 12'h400, 32'h0, 4'h0, r, e, d, lat, clr);
    vec++;
    if (e !== 3'b001 || r !== 3'b000 || d[31:0] !== 32'h0 || lat !== 2 || !clr) begin
      errs++; $display("FAIL oor_read: got err=%b rdy=%b dout=%h lat=%0d clr=%0d expected 001 000 0 2 1", e, r, d[31:0], lat, clr);
    end
    a_one(2, 12'h400, 32'hFFFFFFFF, 4'hF, r, e, d, lat, clr);
    vec++;
    if (e !== 3'b100 || r !== 3'b000) begin errs++; $display("FAIL oor_write: got err=%b rdy=%b expected 100 000", e, r); end
    a_one(0, 12'h000, 32'h0, 4'h0, r, e, d, lat, clr);
    vec++;
    if (d[31:0] !== 32'h0BADF00D) begin errs++; $display("FAIL oor_nowrite: got %h expected 0badf00d", d[31:0]); end
    a_one(1, 12'h3FF, 32'h600DCAFE, 4'hF, r, e, d, lat, clr);
    a_one(1, 12'h3FF, 32'h0, 4'h0, r, e, d, lat, clr);
    vec++;
    if (r !== 3'b010 || e !== 3'b000 || d[63:32] !== 32'h600DCAFE) begin
      errs++; $display("FAIL top_word: got rdy=%b err=%b dout=%h expected 010 000 600dcafe", r, e, d[63:32]);
    end
  endtask

  task automatic test_random();
    logic [2:0] r, e, er, ee, en; logic [95:0] d, ed, din, mask;
    logic [35:0] addr; logic [11:0] wr; int lat; bit clr;
    for (int i = 0; i < 8; i++) begin
      a_one(i % 3, 12'(12'h100 + i), $urandom, 4'hF, r, e, d, lat, clr);
    end
    for (int it = 0; it < 60; it++) begin
      en = 3'($urandom_range(1, 7));
      mask = '0;
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 7) == 0) addr[p*12 +: 12] = 12'($urandom_range(1024, 4095));
        else addr[p*12 +: 12] = 12'(12'h100 + $urandom_range(0, 7));
        wr[p*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        din[p*32 +: 32] = $urandom;
        if (en[p]) mask[p*32 +: 32] = '1;
      end
      a_txn(en, addr, din, wr, r, e, d, lat, clr);
      a_model(en, addr, din, wr, er, ee, ed);
      vec++;
      if (r !== er || e !== ee || lat !== 2 || !clr) begin
        errs++; $display("FAIL rand_strobe[%0d]: got rdy=%b err=%b lat=%0d clr=%0d expected %b %b 2 1", it, r, e, lat, clr, er, ee);
      end
      vec++;
      if ((d & mask) !== (ed & mask)) begin
        errs++; $display("FAIL rand_data[%0d]: got %h expected %h", it, d & mask, ed & mask);
      end
    end
  endtask

  task automatic test_abort_reset();
    logic [31:0] d; logic r, e; int lat, strobes;
    logic [2:0] ar, ae; logic [95:0] ad; bit clr;
    b_txn(12'h040, 32'hCAFEF00D, 4'hF, d, r, e, lat);
    vec++;
    if (lat !== 4 || r !== 1'b1) begin errs++; $display("FAIL ws3_latency: got lat=%0d rdy=%b expected 4 1", lat, r); end
    // write held for two sampling edges, then withdrawn
    @(negedge clk);
    b_en = 1'b1; b_addr = 12'h040; b_din = 32'h12345678; b_wr = 4'hF;
    strobes = 0;
    repeat (2) begin @(negedge clk); if (b_rdy || b_err) strobes++; end
    b_en = 1'b0;
    repeat (6) begin @(negedge clk); if (b_rdy || b_err) strobes++; end
    vec++;
    if (strobes !== 0) begin errs++; $display("FAIL abort_strobe: got %0d strobes expected 0", strobes); end
    b_txn(12'h040, 32'h0, 4'h0, d, r, e, lat);
    vec++;
    if (d !== 32'hCAFEF00D || lat !== 4) begin errs++; $display("FAIL abort_nowrite: got %h lat=%0d expected cafef00d 4", d, lat); end
    // reset pulse in the middle of a wait period
    @(negedge clk);
    b_en = 1'b1; b_addr = 12'h040; b_wr = 4'h0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({b_dout, b_rdy, b_err} !== '0) begin errs++; $display("FAIL reset_mid_wait: got %h expected 0", {b_dout, b_rdy, b_err}); end
    b_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    b_txn(12'h040, 32'h0, 4'h0, d, r, e, lat);
    vec++;
    if (d !== 32'hCAFEF00D || r !== 1'b1) begin errs++; $display("FAIL reset_retain_b: got %h rdy=%b expected cafef00d 1", d, r); end
    a_one(1, 12'h020, 32'h0, 4'h0, ar, ae, ad, lat, clr);
    vec++;
    if (ad[63:32] !== 32'hAA22AA44) begin errs++; $display("FAIL reset_retain_a: got %h expected aa22aa44", ad[63:32]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] dat [8];
    int pulses;
    for (int j = 0; j < 8; j++) dat[j] = $urandom;
    for (int phase = 0; phase < 2; phase++) begin
      pulses = 0;
      @(negedge clk);
      c_en = 1'b1; c_addr = 12'h080; c_din = dat[0]; c_wr = (phase == 0) ? 4'hF : 4'h0;
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        if (c_rdy) pulses++;
        if (phase == 0) mc[12'h080 + j] = dat[j];
        else begin
          vec++;
          if (c_rdy !== 1'b1 || c_dout !== mc[12'h080 + j]) begin
            errs++; $display("FAIL b2b_read[%0d]: got rdy=%b dout=%h expected 1 %h", j, c_rdy, c_dout, mc[12'h080 + j]);
          end
        end
        if (j < 7) begin c_addr = 12'(12'h080 + j + 1); c_din = dat[j+1]; end
        else c_en = 1'b0;
      end
      @(negedge clk);
      vec++;
      if (pulses !== 8 || c_rdy !== 1'b0) begin
        errs++; $display("FAIL b2b_pulses[%0d]: got %0d pulses, trailing rdy=%b expected 8 0", phase, pulses, c_rdy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_byte_lanes();
    test_same_edge();
    test_out_of_range();
    test_random();
    test_abort_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
